// File: rtl/uart_text_buffer_if.sv
// rtl/uart_text_buffer_if.sv - receive-byte input and character-RAM write port bundle
interface uart_text_buffer_if #(
  parameter int COLS = 16,
  parameter int ROWS = 2
);
  localparam int AW = $clog2(COLS * ROWS);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic          rx_vld;
  logic [7:0]    rx_d;
  logic          rx_break;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_d;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic          busy;
  logic          drop;

  modport master (
    output rx_vld, rx_d, rx_break,
    input  wr_en, wr_addr, wr_d, cursor_row, cursor_col, busy, drop
  );

  modport slave (
    input  rx_vld, rx_d, rx_break,
    output wr_en, wr_addr, wr_d, cursor_row, cursor_col, busy, drop
  );
endinterface

// File: rtl/uart_text_buffer.sv
// rtl/uart_text_buffer.sv - UART byte stream to LCD character-RAM writes with cursor
module uart_text_buffer #(
  parameter int COLS = 16,
  parameter int ROWS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_text_buffer_if.slave  bus
);
  localparam int AW = $clog2(COLS * ROWS);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_n;
  logic [AW-1:0] clr_cnt, clr_cnt_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic          wr_en_n, drop_n;
  logic [AW-1:0] wr_addr_n;
  logic [7:0]    wr_d_n;

  // Full-width row*COLS+col, truncated to the RAM address width.
  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [31:0] a;
    a = 32'(r) * 32'(COLS) + 32'(c);
    return a[AW-1:0];
  endfunction

  function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
    return (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      row         <= '0;
      col         <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_d    <= 8'h20;
      bus.drop    <= 1'b0;
    end else begin
      state       <= state_n;
      clr_cnt     <= clr_cnt_n;
      row         <= row_n;
      col         <= col_n;
      bus.wr_en   <= wr_en_n;
      bus.wr_addr <= wr_addr_n;
      bus.wr_d    <= wr_d_n;
      bus.drop    <= drop_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    row_n     = row;
    col_n     = col;
    wr_en_n   = 1'b0;
    wr_addr_n = bus.wr_addr;
    wr_d_n    = bus.wr_d;
    drop_n    = 1'b0;
    unique case (state)
      CLEAR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = clr_cnt;
        wr_d_n    = 8'h20;
        row_n     = '0;
        col_n     = '0;
        drop_n    = bus.rx_vld;
        if (clr_cnt == AW'(COLS * ROWS - 1)) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (bus.rx_vld) begin
          if (bus.rx_break || bus.rx_d == 8'h0C) begin
            state_n = CLEAR;
            row_n   = '0;
            col_n   = '0;
          end else if (bus.rx_d >= 8'h20 && bus.rx_d <= 8'h7E) begin
            wr_en_n   = 1'b1;
            wr_addr_n = addr_of(row, col);
            wr_d_n    = bus.rx_d;
            if (col == CW'(COLS - 1)) begin
              col_n = '0;
              row_n = row_inc(row);
            end else begin
              col_n = col + 1'b1;
            end
          end else if (bus.rx_d == 8'h0D) begin
            col_n = '0;
          end else if (bus.rx_d == 8'h0A) begin
            row_n = row_inc(row);
          end else if (bus.rx_d == 8'h08 && col != '0) begin
            // Backspace blanks the cell it steps back onto.
            col_n     = col - 1'b1;
            wr_en_n   = 1'b1;
            wr_addr_n = addr_of(row, col - 1'b1);
            wr_d_n    = 8'h20;
          end
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  assign bus.cursor_row = row;
  assign bus.cursor_col = col;
  assign bus.busy       = (state == CLEAR);
endmodule

// File: tb/tb_uart_text_buffer.sv
// tb/tb_uart_text_buffer.sv - scoreboard bench for uart_text_buffer (COLS=16, ROWS=2)
module tb_uart_text_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  uart_text_buffer_if #(.COLS(16), .ROWS(2)) bus ();

  uart_text_buffer #(.COLS(16), .ROWS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", int'(bus.wr_addr), -1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", int'(bus.wr_addr), e.addr);
        check("write_data", int'(bus.wr_d), e.data);
      end
    end
  end

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 32; i++) push_wr(i, 8'h20);
  endtask

  task automatic send(input logic [7:0] b, input logic brk);
    @(negedge clk);
    bus.rx_vld   = 1'b1;
    bus.rx_d     = b;
    bus.rx_break = brk;
    @(negedge clk);
    bus.rx_vld   = 1'b0;
    bus.rx_break = 1'b0;
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, int'(bus.cursor_row), r);
    check({name, "_col"}, int'(bus.cursor_col), c);
  endtask

  // Wait for busy to fall; it must drop together with the addr-31 write.
  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        check({name, "_cursor_held"}, int'({bus.cursor_row, bus.cursor_col}), 0);
      end else begin
        done = 1;
        check({name, "_last_addr"}, int'(bus.wr_addr), 31);
        check({name, "_last_en"}, int'(bus.wr_en), 1);
      end
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_wr_en"}, int'(bus.wr_en), 0);
    check({name, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({name, "_wr_d"}, int'(bus.wr_d), 8'h20);
    check({name, "_busy"}, int'(bus.busy), 1);
    check({name, "_drop"}, int'(bus.drop), 0);
    check_cursor(name, 0, 0);
  endtask

  initial begin
    bus.rx_vld   = 1'b0;
    bus.rx_d     = 8'h00;
    bus.rx_break = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    push_clear();
    rst_n = 1'b1;
    wait_idle("powerup_clear");

    push_wr(0, 8'h41);
    send(8'h41, 1'b0);
    check_cursor("after_A", 0, 1);
    send(8'h07, 1'b0);
    check("bel_no_drop", int'(bus.drop), 0);
    check("bel_no_write", int'(bus.wr_en), 0);
    check_cursor("after_bel", 0, 1);

    send(8'h0D, 1'b0);
    check_cursor("cr_row0", 0, 0);
    for (int i = 0; i < 17; i++) begin
      push_wr(i, 8'h61 + i);
      send(8'(8'h61 + i), 1'b0);
    end
    check_cursor("after_17", 1, 1);
    for (int i = 17; i < 32; i++) begin
      push_wr(i, 8'h30 + i);
      send(8'(8'h30 + i), 1'b0);
    end
    check_cursor("after_32_wrap", 0, 0);

    send(8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push_wr(16 + i, 8'h78);
      send(8'h78, 1'b0);
    end
    check_cursor("at_1_5", 1, 5);
    push_wr(20, 8'h20);
    send(8'h08, 1'b0);
    check_cursor("bs", 1, 4);
    send(8'h0D, 1'b0);
    check_cursor("cr", 1, 0);
    send(8'h08, 1'b0);
    check("bs_col0_no_write", int'(bus.wr_en), 0);
    check_cursor("bs_col0", 1, 0);
    send(8'h0A, 1'b0);
    check_cursor("lf_wrap", 0, 0);

    send(8'h0A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_wr(16 + i, 8'h79);
      send(8'h79, 1'b0);
    end
    check_cursor("at_1_3", 1, 3);
    send(8'h0C, 1'b0);
    check("ff_busy", int'(bus.busy), 1);
    check("ff_no_write", int'(bus.wr_en), 0);
    check_cursor("ff", 0, 0);
    push_clear();
    send(8'h42, 1'b0);
    check("drop_pulse", int'(bus.drop), 1);
    @(negedge clk);
    check("drop_one_cycle", int'(bus.drop), 0);
    wait_idle("ff_clear");

    send(8'h00, 1'b1);
    check("brk_busy", int'(bus.busy), 1);
    push_clear();
    wait_idle("brk_clear");

    send(8'h0C, 1'b0);
    for (int i = 0; i <= 10; i++) push_wr(i, 8'h20);
    begin
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (bus.wr_en && bus.wr_addr == 10) hit = 1;
      end
      if (!hit) check("abort_wait_timeout", 0, 1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    check("abort_queue_empty", exp_q.size(), 0);
    push_clear();
    rst_n = 1'b1;
    wait_idle("restart_clear");

    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
